// File: rtl/ni_rx_unpacker.sv
// Receive-side unpacker: pops one DSIZE-bit packet from the NI async FIFO and
// presents it to lwnet as two RSIZE-bit half-words, header (upper half) first.
module ni_rx_unpacker #(
   parameter int MSB_SLOT = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          fifo_rempty,
   input  logic [(1<<MSB_SLOT)-1:0]      fifo_rdata,
   output logic                          fifo_rinc,
   input  logic                          ni_read_en,
   output logic                          ni_rempty,
   output logic [(1<<(MSB_SLOT-1))-1:0]  ni_rdata,
   output logic                          ni_half,
   output logic                          underflow,
   output logic [1:0]                    dbg_state_o
);

   localparam int DSIZE = 1 << MSB_SLOT;
   localparam int RSIZE = 1 << (MSB_SLOT - 1);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_HI    = 2'd1;
   localparam logic [1:0] ST_LO    = 2'd2;

   // Handshake: a half-word is offered while ni_rempty is low and is consumed
   // on any edge where ni_read_en is high; the FIFO head is taken on an edge
   // where fifo_rinc is high, which only happens while fifo_rempty is low.

   logic [1:0]       state_q, state_d;
   logic [DSIZE-1:0] pkt_q, pkt_d;
   logic             underflow_q, underflow_d;
   logic             pop;

   // The reset gate keeps the pop strobe quiet while reset is held.
   assign pop = reset && !fifo_rempty &&
                ((state_q == ST_EMPTY) || ((state_q == ST_LO) && ni_read_en));

   always_comb begin
      state_d     = state_q;
      pkt_d       = pkt_q;
      underflow_d = underflow_q || (ni_read_en && (state_q == ST_EMPTY));
      case (state_q)
         ST_EMPTY: if (pop)        state_d = ST_HI;
         ST_HI:    if (ni_read_en) state_d = ST_LO;
         ST_LO:    if (ni_read_en) state_d = pop ? ST_HI : ST_EMPTY;
         default:                  state_d = ST_EMPTY;
      endcase
      if (pop) pkt_d = fifo_rdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         pkt_q       <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pkt_q       <= pkt_d;
         underflow_q <= underflow_d;
      end
   end

   always_comb begin
      ni_rdata = '0;
      case (state_q)
         ST_HI:   ni_rdata = pkt_q[DSIZE-1:RSIZE];
         ST_LO:   ni_rdata = pkt_q[RSIZE-1:0];
         default: ni_rdata = '0;
      endcase
   end

   assign fifo_rinc   = pop;
   assign ni_rempty   = (state_q == ST_EMPTY);
   assign ni_half     = (state_q == ST_HI);
   assign underflow   = underflow_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ni_rx_unpacker.sv
// Bench for ni_rx_unpacker: directed vector table, hand-written corner
// sequences and randomized traffic against a half-word queue model.
module tb_ni_rx_unpacker;

  typedef struct {
    logic        push;
    logic [31:0] pkt;
    logic        re;
    logic        rinc;
    logic        rempty;
    logic [15:0] rdata;
    logic        half;
    logic        uf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_rempty;
  logic [31:0] fifo_rdata;
  logic        fifo_rinc;
  logic        ni_read_en;
  logic        ni_rempty;
  logic [15:0] ni_rdata;
  logic        ni_half;
  logic        underflow;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0] fq[$];       // packets waiting in the upstream FIFO
  logic [15:0] exp_q[$];    // half-words lwnet has yet to consume
  logic        uf_m;
  vec_t        tab[10];
  vec_t        none;

  ni_rx_unpacker dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .ni_read_en  (ni_read_en),
    .ni_rempty   (ni_rempty),
    .ni_rdata    (ni_rdata),
    .ni_half     (ni_half),
    .underflow   (underflow),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A packet is taken whenever lwnet has nothing left, or is consuming its last half.
  function automatic logic model_rinc(input logic re);
    return reset && (fq.size() != 0) &&
           ((exp_q.size() == 0) || ((exp_q.size() == 1) && re));
  endfunction

  // Called at a negedge; drives inputs, checks, advances one clock, returns at negedge.
  task automatic cycle(input logic re, input bit use_tab, input vec_t v);
    logic        er;
    logic [31:0] p;
    ni_read_en  = re;
    fifo_rempty = (fq.size() == 0);
    fifo_rdata  = (fq.size() != 0) ? fq[0] : $urandom();
    #1;
    er = model_rinc(re);
    chk("m_rinc",   {31'd0, fifo_rinc}, {31'd0, er});
    chk("m_rempty", {31'd0, ni_rempty}, {31'd0, exp_q.size() == 0});
    chk("m_rdata",  {16'd0, ni_rdata},  {16'd0, (exp_q.size() != 0) ? exp_q[0] : 16'd0});
    chk("m_half",   {31'd0, ni_half},   {31'd0, exp_q.size() == 2});
    chk("m_uflow",  {31'd0, underflow}, {31'd0, uf_m});
    if (use_tab) begin
      chk("t_rinc",   {31'd0, fifo_rinc}, {31'd0, v.rinc});
      chk("t_rempty", {31'd0, ni_rempty}, {31'd0, v.rempty});
      chk("t_rdata",  {16'd0, ni_rdata},  {16'd0, v.rdata});
      chk("t_half",   {31'd0, ni_half},   {31'd0, v.half});
      chk("t_uflow",  {31'd0, underflow}, {31'd0, v.uf});
    end
    @(posedge clk);
    if (re && exp_q.size() == 0) uf_m = 1'b1;
    if (re && exp_q.size() != 0) void'(exp_q.pop_front());
    if (er) begin
      p = fq.pop_front();
      exp_q.push_back(p[31:16]);
      exp_q.push_back(p[15:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    none = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    //              push pkt            re    rinc  rempty rdata     half  uf
    tab[0] = '{1'b1, 32'hABCD1234, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    tab[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0};
    tab[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
    tab[3] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    tab[4] = '{1'b1, 32'h11112222, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    tab[5] = '{1'b1, 32'h33334444, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0};
    tab[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0};
    tab[7] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h3333, 1'b1, 1'b0};
    tab[8] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h4444, 1'b0, 1'b0};
    tab[9] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};

    // T1: reset held with a non-empty FIFO
    reset       = 1'b0;
    fifo_rempty = 1'b0;
    fifo_rdata  = 32'hFFFFFFFF;
    ni_read_en  = 1'b0;
    uf_m        = 1'b0;
    #23;
    chk("rst_rinc",   {31'd0, fifo_rinc}, 32'd0);
    chk("rst_rempty", {31'd0, ni_rempty}, 32'd1);
    chk("rst_rdata",  {16'd0, ni_rdata},  32'd0);
    chk("rst_half",   {31'd0, ni_half},   32'd0);
    chk("rst_uflow",  {31'd0, underflow}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // T2 + T3: directed vectors
    for (int i = 0; i < 10; i++) begin
      if (tab[i].push) fq.push_back(tab[i].pkt);
      cycle(tab[i].re, 1'b1, tab[i]);
    end

    // T4: stall on the header for 10 cycles
    fq.push_back(32'hDEADBEEF);
    cycle(1'b0, 1'b0, none);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_rdata", {16'd0, ni_rdata}, 32'h0000DEAD);
      chk("stall_rinc",  {31'd0, fifo_rinc}, 32'd0);
      cycle(1'b0, 1'b0, none);
    end
    cycle(1'b1, 1'b0, none);
    #1;
    chk("stall_lo", {16'd0, ni_rdata}, 32'h0000BEEF);
    cycle(1'b1, 1'b0, none);

    // T5: read while empty sets a sticky underflow and touches nothing else
    cycle(1'b1, 1'b0, none);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("uf_sticky", {31'd0, underflow}, 32'd1);
      chk("uf_rempty", {31'd0, ni_rempty}, 32'd1);
      chk("uf_rinc",   {31'd0, fifo_rinc}, 32'd0);
      cycle(1'b0, 1'b0, none);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (fq.size() < 4 && $urandom_range(0, 2) == 0) fq.push_back($urandom());
      cycle($urandom_range(0, 3) != 0, 1'b0, none);
    end
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && fq.size() == 0) break;
      cycle(1'b1, 1'b0, none);
    end

    // T6: reset asserted while in LO
    fq.push_back(32'h77778888);
    cycle(1'b0, 1'b0, none);
    cycle(1'b1, 1'b0, none);
    #1;
    chk("pre_rst_lo", {16'd0, ni_rdata}, 32'h00008888);
    ni_read_en  = 1'b0;
    fifo_rempty = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_rempty", {31'd0, ni_rempty}, 32'd1);
    chk("mid_rst_rdata",  {16'd0, ni_rdata},  32'd0);
    chk("mid_rst_uflow",  {31'd0, underflow}, 32'd0);
    exp_q.delete();
    fq.delete();
    uf_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fq.push_back(32'h55556666);
    cycle(1'b0, 1'b0, none);
    #1;
    chk("post_rst_hi", {16'd0, ni_rdata}, 32'h00005555);
    cycle(1'b1, 1'b0, none);
    cycle(1'b1, 1'b0, none);
    cycle(1'b0, 1'b0, none);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
